// File: rtl/bias_stream_mem.sv
// Bias word store with a host read/write port and a streaming replay engine
// that emits entries 0..cnt-1 for a programmable number of passes.
module bias_stream_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             start,
    input  logic [AW:0]      count,
    input  logic [REP_W-1:0] repeats,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    // Stream port: a beat transfers on a clock edge where out_valid && out_ready;
    // while out_valid=1 and out_ready=0 the data, valid and last are held.
    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW:0]       cnt;
    logic [REP_W-1:0]  rep;
    logic [REP_W-1:0]  pass;
    logic [AW-1:0]     addr;
    logic              final_loaded;

    logic [AW:0]       cnt_in;
    logic [REP_W-1:0]  rep_in;
    logic              at_end;
    logic              wr_ok;
    logic              rd_ok;

    always_comb begin
        cnt_in = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
        rep_in = (repeats == '0) ? REP_W'(1) : repeats;
        at_end = ({1'b0, addr} == (cnt - (AW+1)'(1)));
        wr_ok  = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
        rd_ok  = ({1'b0, rd_addr} < (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rep          <= '0;
            pass         <= '0;
            addr         <= '0;
            final_loaded <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt  <= cnt_in;
                        rep  <= rep_in;
                        busy <= 1'b1;
                        if (cnt_in == '0) begin
                            addr         <= '0;
                            pass         <= '0;
                            final_loaded <= 1'b0;
                            state        <= FINISH;
                        end else begin
                            // Entry 0 is loaded on the start edge so the first beat
                            // is valid in the very next cycle.
                            out_data     <= mem[0];
                            out_valid    <= 1'b1;
                            out_last     <= (cnt_in == (AW+1)'(1));
                            final_loaded <= (cnt_in == (AW+1)'(1)) && (rep_in == REP_W'(1));
                            if (cnt_in == (AW+1)'(1)) begin
                                addr <= '0;
                                pass <= REP_W'(1);
                            end else begin
                                addr <= AW'(1);
                                pass <= '0;
                            end
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready && final_loaded) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else if ((!out_valid || out_ready) && !final_loaded) begin
                        out_data     <= mem[addr];
                        out_valid    <= 1'b1;
                        out_last     <= at_end;
                        final_loaded <= at_end && (pass == (rep - REP_W'(1)));
                        if (at_end) begin
                            addr <= '0;
                            pass <= pass + REP_W'(1);
                        end else begin
                            addr <= addr + AW'(1);
                        end
                    end
                end
                FINISH: begin
                    // An empty run arrives with done still low and spends one
                    // extra cycle here raising it.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_stream_mem.sv
// Bench for bias_stream_mem: a table of stream configurations plus hand-written
// sequences for write coherence, start-while-busy and mid-stream reset.
module tb_bias_stream_mem;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int REP_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             start;
    logic [AW:0]      count;
    logic [REP_W-1:0] repeats;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    always #5 clk = ~clk;

    bias_stream_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .start(start), .count(count), .repeats(repeats),
        .busy(busy), .done(done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    int tests = 0;
    int fails = 0;

    logic [WIDTH:0]   exp_q[$];   // {last, data}
    logic [WIDTH-1:0] rd_q[$];
    logic [WIDTH-1:0] model_mem[DEPTH];

    typedef struct {
        int cnt;
        int rep;
        int mode;       // 0: out_ready held 1, 1: out_ready pattern 1,0,0,1,1
        int done_lat;   // cycles from start to the done pulse
        int busy_cyc;   // -1: not checked
    } row_t;

    row_t rows[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        case ((k - 1) % 5)
            0, 3, 4: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard: stream beats and host reads are popped as the DUT produces them.
    logic           prev_hold = 1'b0;
    logic [WIDTH:0] prev_word = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got beat 0x%0h last=%0b, expected no beat", out_data, out_last);
                end else begin
                    check("beat", {out_last, out_data}, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_last, out_data};
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_rd_valid: got rd_valid=1, expected 0");
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
        end
    end

    task automatic host_write(input int a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic host_read(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        rd_q.push_back(model_mem[a]);
        step();
        rd_en = 1'b0;
    endtask

    task automatic run_stream(input int cnt, input int rep, input int mode,
                              output int done_lat, output int busy_cyc, output int done_pulses);
        int n;
        int r;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        r = (rep == 0) ? 1 : rep;
        for (int p = 0; p < r; p++)
            for (int j = 0; j < n; j++)
                exp_q.push_back({(j == n - 1), model_mem[j]});
        count = (AW+1)'(cnt); repeats = REP_W'(rep); start = 1'b1;
        step();
        start = 1'b0;
        done_lat = -1; busy_cyc = 0; done_pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            out_ready = rdy(mode, k);
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                done_pulses++;
                if (done_lat < 0) done_lat = k;
            end
            if (done_lat >= 0 && k >= done_lat + 3) break;
            step();
        end
        step();
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected bench to end");
        $fatal(1, "timeout");
    end

    initial begin
        int dl, bc, dp, seen;
        rows[0] = '{cnt: 4, rep: 2, mode: 0, done_lat: 9, busy_cyc: 8};
        rows[1] = '{cnt: 3, rep: 1, mode: 1, done_lat: 6, busy_cyc: 5};
        rows[2] = '{cnt: 0, rep: 1, mode: 0, done_lat: 2, busy_cyc: -1};
        rows[3] = '{cnt: 7, rep: 1, mode: 0, done_lat: 5, busy_cyc: 4};
        rows[4] = '{cnt: 2, rep: 0, mode: 0, done_lat: 3, busy_cyc: 2};
        rows[5] = '{cnt: 1, rep: 3, mode: 0, done_lat: 4, busy_cyc: 3};
        rows[6] = '{cnt: 4, rep: 1, mode: 1, done_lat: 7, busy_cyc: 6};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; start = 1'b0; count = '0; repeats = '0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_out_data", out_data, 0);
        step();
        reset = 1'b0;
        host_read(1);

        host_write(0, 32'h11);
        host_write(1, 32'h22);
        host_write(2, 32'h33);
        host_write(3, 32'h44);
        host_read(2);
        @(negedge clk);
        step();
        @(negedge clk);
        check("rd_hold_data", rd_data, 32'h33);
        check("rd_hold_valid", rd_valid, 0);
        step();

        for (int i = 0; i < 7; i++) begin
            run_stream(rows[i].cnt, rows[i].rep, rows[i].mode, dl, bc, dp);
            check($sformatf("row%0d_done_lat", i), dl, rows[i].done_lat);
            if (rows[i].busy_cyc >= 0)
                check($sformatf("row%0d_busy_cycles", i), bc, rows[i].busy_cyc);
            check($sformatf("row%0d_done_pulses", i), dp, 1);
            check($sformatf("row%0d_queue_empty", i), exp_q.size(), 0);
        end

        // Read-before-write on the host port.
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h99;
        rd_en = 1'b1; rd_addr = 2'd1;
        rd_q.push_back(model_mem[1]);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        model_mem[1] = 32'h99;
        host_read(1);
        host_write(1, 32'h22);

        // Write to addr 3 before it is loaded; a second start mid-stream is ignored.
        exp_q.push_back({1'b0, 32'h11});
        exp_q.push_back({1'b0, 32'h22});
        exp_q.push_back({1'b0, 32'h33});
        exp_q.push_back({1'b1, 32'hAA});
        count = 3'd4; repeats = 8'd1; start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'hAA;
        model_mem[3] = 32'hAA;
        step();
        wr_en = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b1; count = 3'd2;
        step();
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            step();
        end
        check("coh_done_seen", seen, 1);
        check("coh_queue_empty", exp_q.size(), 0);
        repeat (3) step();
        check("coh_no_restart", busy, 0);

        // Reset after two beats aborts the stream and clears memory.
        exp_q.push_back({1'b0, model_mem[0]});
        exp_q.push_back({1'b0, model_mem[1]});
        count = 3'd4; repeats = 8'd1; start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1; out_ready = 1'b0;
        step();
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        dp = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            if (done) dp++;
        end
        check("abort_no_done", dp, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        step();
        for (int i = 0; i < DEPTH; i++) host_read(i);
        run_stream(2, 1, 0, dl, bc, dp);
        check("post_reset_done_lat", dl, 3);
        check("post_reset_queue_empty", exp_q.size(), 0);
        repeat (2) step();
        check("rd_queue_empty", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
